// File: rtl/span_writer_if.sv
// Span command handshake plus the off-screen word-write bus of span_writer.
interface span_writer_if;
  logic         span_valid;
  logic         span_ready;
  logic [10:0]  span_x;
  logic [11:0]  span_len;
  logic [7:0]   span_colour;
  logic [6:0]   addr_off_draw;
  logic [15:0]  we_off_draw;
  logic [127:0] colour_off_draw;

  modport master (
    output span_valid, span_x, span_len, span_colour,
    input  span_ready, addr_off_draw, we_off_draw, colour_off_draw
  );

  modport slave (
    input  span_valid, span_x, span_len, span_colour,
    output span_ready, addr_off_draw, we_off_draw, colour_off_draw
  );
endinterface

// File: rtl/span_writer.sv
// Draw-domain span rasteriser into 16-pixel words with a per-line on-screen clear engine.
// The clear engine is only built when SPAN_WRITER_CLEAR_EN is defined.
module span_writer (
  input  logic          clk_draw,
  input  logic          rst_n,
  input  logic          line_start,
  output logic          buffsel_draw,
  span_writer_if.slave  sif,
  input  logic          clear_adv,
  input  logic [7:0]    bg_colour,
  output logic [6:0]    addr_on_draw,
  output logic          we_on_draw,
  output logic [127:0]  colour_on_draw,
  output logic          busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          span_ready_q, span_ready_d;
  logic          busy_q, busy_d;
  logic          buffsel_q, buffsel_d;
  logic [10:0]   s_q, s_d;
  logic [10:0]   e_q, e_d;
  logic [6:0]    cur_q, cur_d;
  logic [7:0]    colour_q, colour_d;
  logic [6:0]    addr_off_q, addr_off_d;
  logic [15:0]   we_off_q, we_off_d;
  logic [127:0]  colour_off_q, colour_off_d;

  logic          accept_s;
  logic          last_s;
  logic [12:0]   end_full_s;
  logic [3:0]    lo_s, hi_s;

  function automatic logic [15:0] span_mask(input logic [3:0] lo, input logic [3:0] hi);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if ((i >= int'(lo)) && (i <= int'(hi))) m[i] = 1'b1;
      else                                    m[i] = 1'b0;
    end
    return m;
  endfunction

  // Span FSM next state, latched span fields and the next off-screen write.
  always_comb begin
    accept_s     = sif.span_valid && span_ready_q && !line_start;
    // 13-bit sum so a long span clips at pixel 2047 instead of wrapping
    end_full_s   = {2'b00, sif.span_x} + {1'b0, sif.span_len} - 13'd1;
    last_s       = (cur_q == e_q[10:4]);
    lo_s         = (cur_q == s_q[10:4]) ? s_q[3:0] : 4'd0;
    hi_s         = last_s ? e_q[3:0] : 4'd15;
    state_d      = state_q;
    s_d          = s_q;
    e_d          = e_q;
    cur_d        = cur_q;
    colour_d     = colour_q;
    addr_off_d   = addr_off_q;
    we_off_d     = 16'h0000;
    colour_off_d = colour_off_q;
    buffsel_d    = buffsel_q;
    if (line_start) begin
      buffsel_d = ~buffsel_q;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && (sif.span_len != 12'd0)) begin
            state_d  = ST_RUN;
            s_d      = sif.span_x;
            e_d      = (end_full_s > 13'd2047) ? 11'h7FF : end_full_s[10:0];
            cur_d    = sif.span_x[10:4];
            colour_d = sif.span_colour;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          addr_off_d   = cur_q;
          we_off_d     = span_mask(lo_s, hi_s);
          colour_off_d = {16{colour_q}};
          cur_d        = cur_q + 7'd1;
          if (last_s) state_d = ST_IDLE;
          else        state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    span_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d == ST_RUN);
  end

  // Span engine state and registered outputs.
  always_ff @(posedge clk_draw) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      span_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      buffsel_q    <= 1'b0;
      s_q          <= 11'd0;
      e_q          <= 11'd0;
      cur_q        <= 7'd0;
      colour_q     <= 8'd0;
      addr_off_q   <= 7'd0;
      we_off_q     <= 16'h0000;
      colour_off_q <= 128'd0;
    end else begin
      state_q      <= state_d;
      span_ready_q <= span_ready_d;
      busy_q       <= busy_d;
      buffsel_q    <= buffsel_d;
      s_q          <= s_d;
      e_q          <= e_d;
      cur_q        <= cur_d;
      colour_q     <= colour_d;
      addr_off_q   <= addr_off_d;
      we_off_q     <= we_off_d;
      colour_off_q <= colour_off_d;
    end
  end

  assign sif.span_ready      = span_ready_q;
  assign sif.addr_off_draw   = addr_off_q;
  assign sif.we_off_draw     = we_off_q;
  assign sif.colour_off_draw = colour_off_q;
  assign busy                = busy_q;
  assign buffsel_draw        = buffsel_q;

`ifdef SPAN_WRITER_CLEAR_EN
  logic          armed_q, armed_d;
  logic [6:0]    ptr_q, ptr_d;
  logic          we_on_q, we_on_d;
  logic [6:0]    addr_on_q, addr_on_d;
  logic [127:0]  colour_on_q, colour_on_d;

  // Clear engine: line_start re-arms from word 0, each armed clear_adv writes one word.
  always_comb begin
    armed_d     = armed_q;
    ptr_d       = ptr_q;
    we_on_d     = 1'b0;
    addr_on_d   = addr_on_q;
    colour_on_d = colour_on_q;
    if (line_start) begin
      ptr_d   = 7'd0;
      armed_d = 1'b1;
    end else if (clear_adv && armed_q) begin
      we_on_d     = 1'b1;
      addr_on_d   = ptr_q;
      colour_on_d = {16{bg_colour}};
      ptr_d       = ptr_q + 7'd1;
      if (ptr_q == 7'd127) armed_d = 1'b0;
      else                 armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Clear engine registers.
  always_ff @(posedge clk_draw) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      ptr_q       <= 7'd0;
      we_on_q     <= 1'b0;
      addr_on_q   <= 7'd0;
      colour_on_q <= 128'd0;
    end else begin
      armed_q     <= armed_d;
      ptr_q       <= ptr_d;
      we_on_q     <= we_on_d;
      addr_on_q   <= addr_on_d;
      colour_on_q <= colour_on_d;
    end
  end

  assign we_on_draw     = we_on_q;
  assign addr_on_draw   = addr_on_q;
  assign colour_on_draw = colour_on_q;
`else
  logic unused_clear_s;
  assign unused_clear_s = ^{clear_adv, bg_colour};
  assign we_on_draw     = 1'b0;
  assign addr_on_draw   = 7'd0;
  assign colour_on_draw = 128'd0;
`endif

endmodule

// File: tb/tb_span_writer.sv
// Directed self-checking bench for span_writer; clear-engine checks follow SPAN_WRITER_CLEAR_EN.
module tb_span_writer;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_start;
  logic          clear_adv;
  logic [7:0]    bg_colour;
  logic          buffsel_draw;
  logic [6:0]    addr_on_draw;
  logic          we_on_draw;
  logic [127:0]  colour_on_draw;
  logic          busy;
  logic          exp_buf;
  int            n_checks = 0;
  int            n_fail   = 0;

  span_writer_if sif();

  span_writer dut (
    .clk_draw       (clk),
    .rst_n          (rst_n),
    .line_start     (line_start),
    .buffsel_draw   (buffsel_draw),
    .sif            (sif.slave),
    .clear_adv      (clear_adv),
    .bg_colour      (bg_colour),
    .addr_on_draw   (addr_on_draw),
    .we_on_draw     (we_on_draw),
    .colour_on_draw (colour_on_draw),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_span(input logic [10:0] x, input logic [11:0] len, input logic [7:0] col);
    sif.span_valid  = 1'b1;
    sif.span_x      = x;
    sif.span_len    = len;
    sif.span_colour = col;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_start = 1'b0; clear_adv = 1'b0; bg_colour = 8'h00;
    sif.span_valid = 1'b0; sif.span_x = 11'd0; sif.span_len = 12'd0; sif.span_colour = 8'h00;
    exp_buf = 1'b0;
    tick(); tick();
    n_checks++; if ({sif.we_off_draw, sif.addr_off_draw, sif.colour_off_draw} !== 151'd0) begin n_fail++; $display("FAIL reset_off: got %h expected 0", {sif.we_off_draw, sif.addr_off_draw, sif.colour_off_draw}); end
    n_checks++; if ({we_on_draw, addr_on_draw, colour_on_draw} !== 136'd0) begin n_fail++; $display("FAIL reset_on: got %h expected 0", {we_on_draw, addr_on_draw, colour_on_draw}); end
    n_checks++; if ({sif.span_ready, busy, buffsel_draw} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {sif.span_ready, busy, buffsel_draw}); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (sif.span_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", sif.span_ready); end
  endtask

  task automatic test_single();
    drive_span(11'd5, 12'd3, 8'h2A);
    tick();
    sif.span_valid = 1'b0;
    n_checks++; if ({sif.span_ready, busy, sif.we_off_draw} !== {1'b0, 1'b1, 16'h0000}) begin n_fail++; $display("FAIL single_accept: got ready=%b busy=%b we=%h expected 0 1 0000", sif.span_ready, busy, sif.we_off_draw); end
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw} !== {7'd0, 16'h00E0}) begin n_fail++; $display("FAIL single_write: got addr=%0d we=%h expected 0 00e0", sif.addr_off_draw, sif.we_off_draw); end
    n_checks++; if (sif.colour_off_draw !== {16{8'h2A}}) begin n_fail++; $display("FAIL single_data: got %h expected %h", sif.colour_off_draw, {16{8'h2A}}); end
    n_checks++; if ({sif.span_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b expected 10", {sif.span_ready, busy}); end
    tick();
    n_checks++; if (sif.we_off_draw !== 16'h0000) begin n_fail++; $display("FAIL single_idle_we: got %h expected 0000", sif.we_off_draw); end
  endtask

  task automatic test_multi_word();
    logic [15:0] exp_we [3];
    exp_we[0] = 16'hC000; exp_we[1] = 16'hFFFF; exp_we[2] = 16'h0003;
    drive_span(11'd14, 12'd20, 8'h7E);
    tick();
    sif.span_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({sif.addr_off_draw, sif.we_off_draw} !== {7'(i), exp_we[i]}) begin n_fail++; $display("FAIL multi_word%0d: got addr=%0d we=%h expected %0d %h", i, sif.addr_off_draw, sif.we_off_draw, i, exp_we[i]); end
    end
    n_checks++; if ({sif.span_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL multi_ready: got %b expected 10", {sif.span_ready, busy}); end
    tick();
    n_checks++; if (sif.we_off_draw !== 16'h0000) begin n_fail++; $display("FAIL multi_idle_we: got %h expected 0000", sif.we_off_draw); end
  endtask

  task automatic test_clip();
    drive_span(11'd2040, 12'd100, 8'h33);
    tick();
    sif.span_valid = 1'b0;
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw} !== {7'd127, 16'hFF00}) begin n_fail++; $display("FAIL clip_write: got addr=%0d we=%h expected 127 ff00", sif.addr_off_draw, sif.we_off_draw); end
    tick();
    n_checks++; if ({sif.we_off_draw, sif.span_ready} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL clip_no_wrap: got we=%h ready=%b expected 0000 1", sif.we_off_draw, sif.span_ready); end
  endtask

  task automatic test_zero_len();
    drive_span(11'd100, 12'd0, 8'h44);
    tick();
    sif.span_valid = 1'b0;
    n_checks++; if ({sif.span_ready, busy, sif.we_off_draw} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL zero_len_accept: got ready=%b busy=%b we=%h expected 1 0 0000", sif.span_ready, busy, sif.we_off_draw); end
    tick();
    n_checks++; if ({busy, sif.we_off_draw} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL zero_len_idle: got busy=%b we=%h expected 0 0000", busy, sif.we_off_draw); end
  endtask

  task automatic test_back_to_back();
    drive_span(11'd0, 12'd1, 8'h01);
    tick();
    drive_span(11'd32, 12'd16, 8'h02);
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw, sif.span_ready} !== {7'd0, 16'h0001, 1'b1}) begin n_fail++; $display("FAIL b2b_first: got addr=%0d we=%h ready=%b expected 0 0001 1", sif.addr_off_draw, sif.we_off_draw, sif.span_ready); end
    tick();
    sif.span_valid = 1'b0;
    n_checks++; if ({busy, sif.span_ready, sif.we_off_draw} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL b2b_second_accept: got busy=%b ready=%b we=%h expected 1 0 0000", busy, sif.span_ready, sif.we_off_draw); end
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw, sif.colour_off_draw} !== {7'd2, 16'hFFFF, {16{8'h02}}}) begin n_fail++; $display("FAIL b2b_second: got addr=%0d we=%h data=%h expected 2 ffff 02..", sif.addr_off_draw, sif.we_off_draw, sif.colour_off_draw); end
  endtask

  task automatic test_abort();
    drive_span(11'd0, 12'd2048, 8'h55);
    tick();
    sif.span_valid = 1'b0;
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw} !== {7'd0, 16'hFFFF}) begin n_fail++; $display("FAIL abort_w0: got addr=%0d we=%h expected 0 ffff", sif.addr_off_draw, sif.we_off_draw); end
    tick();
    n_checks++; if ({sif.addr_off_draw, sif.we_off_draw} !== {7'd1, 16'hFFFF}) begin n_fail++; $display("FAIL abort_w1: got addr=%0d we=%h expected 1 ffff", sif.addr_off_draw, sif.we_off_draw); end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    exp_buf = ~exp_buf;
    n_checks++; if ({sif.we_off_draw, sif.span_ready, busy, buffsel_draw} !== {16'h0000, 1'b1, 1'b0, exp_buf}) begin n_fail++; $display("FAIL abort_stop: got we=%h ready=%b busy=%b buf=%b expected 0000 1 0 %b", sif.we_off_draw, sif.span_ready, busy, buffsel_draw, exp_buf); end
    tick();
    n_checks++; if (sif.we_off_draw !== 16'h0000) begin n_fail++; $display("FAIL abort_after: got %h expected 0000", sif.we_off_draw); end
  endtask

  task automatic test_line_start_priority();
    drive_span(11'd64, 12'd16, 8'h66);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    sif.span_valid = 1'b0;
    exp_buf = ~exp_buf;
    n_checks++; if ({busy, sif.span_ready, buffsel_draw} !== {1'b0, 1'b1, exp_buf}) begin n_fail++; $display("FAIL prio_ctl: got busy=%b ready=%b buf=%b expected 0 1 %b", busy, sif.span_ready, buffsel_draw, exp_buf); end
    tick();
    n_checks++; if ({busy, sif.we_off_draw} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL prio_no_write: got busy=%b we=%h expected 0 0000", busy, sif.we_off_draw); end
  endtask

  task automatic test_clear();
    int n_clears;
    bg_colour = 8'h11;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    exp_buf = ~exp_buf;
    n_checks++; if (we_on_draw !== 1'b0) begin n_fail++; $display("FAIL clear_arm: got we_on=%b expected 0", we_on_draw); end
`ifdef SPAN_WRITER_CLEAR_EN
    n_clears = 0;
    for (int i = 0; i < 130; i++) begin
      clear_adv = 1'b1;
      tick();
      if (we_on_draw === 1'b1) n_clears++;
      if (i < 128) begin
        n_checks++; if ({we_on_draw, addr_on_draw, colour_on_draw} !== {1'b1, 7'(i), {16{8'h11}}}) begin n_fail++; $display("FAIL clear_word%0d: got we=%b addr=%0d data=%h", i, we_on_draw, addr_on_draw, colour_on_draw); end
      end else begin
        n_checks++; if (we_on_draw !== 1'b0) begin n_fail++; $display("FAIL clear_extra%0d: got we=%b expected 0", i, we_on_draw); end
      end
    end
    n_checks++; if (n_clears != 128) begin n_fail++; $display("FAIL clear_count: got %0d expected 128", n_clears); end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    exp_buf = ~exp_buf;
    n_checks++; if (we_on_draw !== 1'b0) begin n_fail++; $display("FAIL clear_ls_wins: got we=%b expected 0", we_on_draw); end
    tick();
    clear_adv = 1'b0;
    n_checks++; if ({we_on_draw, addr_on_draw} !== {1'b1, 7'd0}) begin n_fail++; $display("FAIL clear_rearm: got we=%b addr=%0d expected 1 0", we_on_draw, addr_on_draw); end
`else
    n_clears = 0;
    for (int i = 0; i < 4; i++) begin
      clear_adv = 1'b1;
      tick();
      if ({we_on_draw, addr_on_draw, colour_on_draw} !== 136'd0) n_clears++;
    end
    clear_adv = 1'b0;
    n_checks++; if (n_clears != 0) begin n_fail++; $display("FAIL clear_disabled: got %0d active cycles expected 0", n_clears); end
`endif
    n_checks++; if (buffsel_draw !== exp_buf) begin n_fail++; $display("FAIL clear_buf: got %b expected %b", buffsel_draw, exp_buf); end
  endtask

  task automatic test_reset_mid_span();
    drive_span(11'd0, 12'd2048, 8'h77);
    tick();
    sif.span_valid = 1'b0;
    tick();
    n_checks++; if (sif.we_off_draw !== 16'hFFFF) begin n_fail++; $display("FAIL rst_mid_pre: got %h expected ffff", sif.we_off_draw); end
    rst_n = 1'b0;
    exp_buf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({sif.we_off_draw, we_on_draw, busy, sif.span_ready, buffsel_draw} !== 20'd0) begin n_fail++; $display("FAIL rst_mid_hold%0d: got we=%h we_on=%b busy=%b ready=%b buf=%b expected all 0", i, sif.we_off_draw, we_on_draw, busy, sif.span_ready, buffsel_draw); end
    end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({sif.span_ready, busy, sif.we_off_draw} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL rst_mid_release: got ready=%b busy=%b we=%h expected 1 0 0000", sif.span_ready, busy, sif.we_off_draw); end
    tick();
    n_checks++; if (sif.we_off_draw !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_dropped: got %h expected 0000", sif.we_off_draw); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_word();
    test_clip();
    test_zero_len();
    test_back_to_back();
    test_abort();
    test_line_start_priority();
    test_clear();
    test_reset_mid_span();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
